// File: rtl/riscv_corememarb.sv
// Two-to-one memory port arbiter: merges core imem/dmem requests onto one memory
// port and routes in-order memory responses back to the issuing core port.
module riscv_corememarb #(
  parameter int REQ_SZ    = 67,
  parameter int RESP_SZ   = 35,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic [REQ_SZ-1:0]            imemreq_msg,
  input  logic                         imemreq_val,
  output logic                         imemreq_rdy,
  output logic [RESP_SZ-1:0]           imemresp_msg,
  output logic                         imemresp_val,

  input  logic [REQ_SZ-1:0]            dmemreq_msg,
  input  logic                         dmemreq_val,
  output logic                         dmemreq_rdy,
  output logic [RESP_SZ-1:0]           dmemresp_msg,
  output logic                         dmemresp_val,

  output logic [REQ_SZ-1:0]            memreq_msg,
  output logic                         memreq_val,
  input  logic                         memreq_rdy,
  input  logic [RESP_SZ-1:0]           memresp_msg,
  input  logic                         memresp_val,

  output logic [$clog2(MAX_OUTST):0]   outstanding,
  output logic                         err
);

  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;

  logic [MAX_OUTST-1:0] tags;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 last_grant;

  logic full;
  logic grant_i;
  logic grant_d;
  logic fire;
  logic pop;
  logic head_tag;

  assign full = (count == CW'(MAX_OUTST));

  // Round-robin grant; nothing is granted when full or while reset is held so
  // that a pop in the same cycle never opens a response-to-request path.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (reset && !full) begin
      if (imemreq_val && !dmemreq_val) begin
        grant_i = 1'b1;
      end else if (dmemreq_val && !imemreq_val) begin
        grant_d = 1'b1;
      end else if (imemreq_val && dmemreq_val) begin
        if (last_grant) grant_i = 1'b1;
        else            grant_d = 1'b1;
      end
    end
  end

  assign memreq_val  = grant_i | grant_d;
  assign memreq_msg  = grant_d ? dmemreq_msg : imemreq_msg;
  assign imemreq_rdy = grant_i & memreq_rdy;
  assign dmemreq_rdy = grant_d & memreq_rdy;
  assign fire        = memreq_val & memreq_rdy;

  // A response only pops when a tag from an earlier cycle is waiting.
  assign pop          = reset & memresp_val & (count != '0);
  assign head_tag     = tags[rd_ptr];
  assign imemresp_val = pop & ~head_tag;
  assign dmemresp_val = pop &  head_tag;
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;

  assign outstanding = count;

  // Tag FIFO, pointers, in-flight count, round-robin history and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tags       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      err        <= 1'b0;
    end else begin
      if (fire) begin
        tags[wr_ptr] <= grant_d;
        wr_ptr       <= wr_ptr + 1'b1;
        last_grant   <= grant_d;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (memresp_val && count == '0) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_corememarb.sv
// Scoreboard bench for riscv_corememarb: a tag queue predicts the routing of
// every response, and directed plus random traffic exercises the arbiter.
module tb_riscv_corememarb;

  logic          clk;
  logic          reset;
  logic [66:0]   imemreq_msg;
  logic          imemreq_val;
  logic          imemreq_rdy;
  logic [34:0]   imemresp_msg;
  logic          imemresp_val;
  logic [66:0]   dmemreq_msg;
  logic          dmemreq_val;
  logic          dmemreq_rdy;
  logic [34:0]   dmemresp_msg;
  logic          dmemresp_val;
  logic [66:0]   memreq_msg;
  logic          memreq_val;
  logic          memreq_rdy;
  logic [34:0]   memresp_msg;
  logic          memresp_val;
  logic [2:0]    outstanding;
  logic          err;

  riscv_corememarb dut (
    .clk          (clk),
    .reset        (reset),
    .imemreq_msg  (imemreq_msg),
    .imemreq_val  (imemreq_val),
    .imemreq_rdy  (imemreq_rdy),
    .imemresp_msg (imemresp_msg),
    .imemresp_val (imemresp_val),
    .dmemreq_msg  (dmemreq_msg),
    .dmemreq_val  (dmemreq_val),
    .dmemreq_rdy  (dmemreq_rdy),
    .dmemresp_msg (dmemresp_msg),
    .dmemresp_val (dmemresp_val),
    .memreq_msg   (memreq_msg),
    .memreq_val   (memreq_val),
    .memreq_rdy   (memreq_rdy),
    .memresp_msg  (memresp_msg),
    .memresp_val  (memresp_val),
    .outstanding  (outstanding),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];
  logic m_last;
  logic m_err;
  logic obs_i;
  logic obs_d;
  logic obs_fire;

  task automatic check_output(input string tag, input logic [66:0] obs, input logic [66:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, check against the model, then advance the model.
  task automatic apply_stimulus(input logic iv, input logic dv, input logic mrdy,
                                input logic rv, input logic [66:0] im,
                                input logic [66:0] dm, input logic [34:0] rm);
    logic full_m, gi, gd, pop, head, was_empty, junk;
    imemreq_val = iv;
    dmemreq_val = dv;
    memreq_rdy  = mrdy;
    memresp_val = rv;
    imemreq_msg = im;
    dmemreq_msg = dm;
    memresp_msg = rm;
    #1;
    full_m = (exp_q.size() == 4);
    gi = 1'b0;
    gd = 1'b0;
    if (!full_m) begin
      if (iv && !dv)      gi = 1'b1;
      else if (dv && !iv) gd = 1'b1;
      else if (iv && dv) begin
        if (m_last) gi = 1'b1;
        else        gd = 1'b1;
      end
    end
    was_empty = (exp_q.size() == 0);
    pop  = rv && !was_empty;
    head = pop ? exp_q[0] : 1'b0;
    check_output("memreq_val",   67'(memreq_val),   67'(gi | gd));
    check_output("imemreq_rdy",  67'(imemreq_rdy),  67'(gi & mrdy));
    check_output("dmemreq_rdy",  67'(dmemreq_rdy),  67'(gd & mrdy));
    check_output("memreq_msg",   memreq_msg,        gd ? dm : im);
    check_output("imemresp_val", 67'(imemresp_val), 67'(pop & ~head));
    check_output("dmemresp_val", 67'(dmemresp_val), 67'(pop & head));
    if (rv) begin
      check_output("imemresp_msg", 67'(imemresp_msg), 67'(rm));
      check_output("dmemresp_msg", 67'(dmemresp_msg), 67'(rm));
    end
    check_output("outstanding", 67'(outstanding), 67'(exp_q.size()));
    check_output("err",         67'(err),         67'(m_err));
    obs_i    = imemreq_rdy;
    obs_d    = dmemreq_rdy;
    obs_fire = memreq_val & memreq_rdy;
    @(posedge clk);
    if (pop) junk = exp_q.pop_front();
    if ((gi | gd) && mrdy) begin
      exp_q.push_back(gd);
      m_last = gd;
    end
    if (rv && was_empty) m_err = 1'b1;
    @(negedge clk);
  endtask

  // Pull reset low mid-cycle with traffic active; everything must clear at once.
  task automatic pulse_reset();
    imemreq_val = 1'b1;
    dmemreq_val = 1'b1;
    memreq_rdy  = 1'b1;
    memresp_val = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_output("rst_memreq_val",   67'(memreq_val),   67'(0));
    check_output("rst_imemreq_rdy",  67'(imemreq_rdy),  67'(0));
    check_output("rst_dmemreq_rdy",  67'(dmemreq_rdy),  67'(0));
    check_output("rst_imemresp_val", 67'(imemresp_val), 67'(0));
    check_output("rst_dmemresp_val", 67'(dmemresp_val), 67'(0));
    check_output("rst_outstanding",  67'(outstanding),  67'(0));
    check_output("rst_err",          67'(err),          67'(0));
    exp_q.delete();
    m_last = 1'b1;
    m_err  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [66:0] ia;
  logic [66:0] da;
  logic [34:0] r0;
  logic [3:0]  seq;
  int          fires;

  initial begin
    reset = 1'b0;
    imemreq_val = 1'b0;
    dmemreq_val = 1'b0;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    imemreq_msg = '0;
    dmemreq_msg = '0;
    memresp_msg = '0;
    exp_q.delete();
    m_last = 1'b1;
    m_err  = 1'b0;
    ia = {1'b0, 32'h0000_0200, 2'b00, 32'h0};
    da = {1'b1, 32'h0000_1000, 2'b00, 32'h1234_5678};
    #2;
    check_output("init_memreq_val", 67'(memreq_val),  67'(0));
    check_output("init_outstanding", 67'(outstanding), 67'(0));
    check_output("init_err",         67'(err),         67'(0));
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] idle and single imem request");
    apply_stimulus(0, 0, 1, 0, ia, da, '0);
    apply_stimulus(1, 0, 1, 0, ia, da, '0);
    check_output("single_irdy", 67'(obs_i), 67'(1));
    apply_stimulus(0, 0, 1, 0, ia, da, '0);
    r0 = {3'b0, 32'hDEAD_BEEF};
    apply_stimulus(0, 0, 1, 1, ia, da, r0);

    $display("[TB] round robin until full");
    seq = '0;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 1, 1, 0, ia, da, '0);
      seq = {seq[2:0], obs_d};
    end
    check_output("rr_sequence", 67'(seq), 67'(4'b1010));
    apply_stimulus(1, 1, 1, 0, ia, da, '0);
    apply_stimulus(1, 1, 1, 0, ia, da, '0);
    for (int k = 0; k < 4; k++)
      apply_stimulus(0, 0, 1, 1, ia, da, {3'b0, 32'hA000_0000 + 32'(k)});

    $display("[TB] mixed I,D,D,I then full with response");
    apply_stimulus(1, 0, 1, 0, ia, da, '0);
    apply_stimulus(0, 1, 1, 0, ia, da, '0);
    apply_stimulus(0, 1, 1, 0, ia, da, '0);
    apply_stimulus(1, 0, 1, 0, ia, da, '0);
    apply_stimulus(0, 1, 1, 1, ia, da, {3'b0, 32'hB000_0000});
    check_output("full_pop_no_issue", 67'(obs_d), 67'(0));
    apply_stimulus(0, 1, 1, 0, ia, da, '0);
    check_output("issue_after_pop", 67'(obs_d), 67'(1));
    for (int k = 1; k < 5; k++)
      apply_stimulus(0, 0, 1, 1, ia, da, {3'b0, 32'hB000_0000 + 32'(k)});

    $display("[TB] memreq_rdy held low");
    fires = 0;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1, 1, 0, 0, ia, da, '0);
      if (obs_fire) fires++;
    end
    check_output("rdy_low_nofire", 67'(fires), 67'(0));
    apply_stimulus(1, 1, 1, 0, ia, da, '0);
    check_output("rdy_high_grant_i", 67'(obs_i), 67'(1));
    apply_stimulus(0, 0, 1, 1, ia, da, {3'b0, 32'hC000_0001});

    $display("[TB] spurious response and mid-transfer reset");
    apply_stimulus(0, 0, 1, 1, ia, da, {3'b0, 32'hE000_0000});
    apply_stimulus(0, 0, 1, 0, ia, da, '0);
    check_output("err_sticky", 67'(err), 67'(1));
    apply_stimulus(1, 0, 1, 0, ia, da, '0);
    apply_stimulus(0, 1, 1, 0, ia, da, '0);
    pulse_reset();
    apply_stimulus(0, 0, 1, 1, ia, da, {3'b0, 32'hE000_0001});
    apply_stimulus(0, 0, 1, 0, ia, da, '0);

    $display("[TB] random traffic");
    for (int k = 0; k < 300; k++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                     {3'($urandom), $urandom, $urandom},
                     {3'($urandom), $urandom, $urandom},
                     {3'($urandom), $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
